slc_nway: RTL

Parametrised N-way set-associative system-level cache for the HN-F. It sits between the snoop-filter lookup and the SN-side request channel. It accepts one CHI request at a time and looks up tag/state across all ways. On a hit it returns the line. On an SLC miss with a snoop-filter miss it writes back a dirty victim if needed, issues ReadNoSnp, installs the fill and returns it. It is blocking: a single outstanding miss, with round-robin replacement per set.

---
 rtl/slc_nway.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/slc_nway.sv
// slc_nway: blocking N-way set-associative system-level cache for the HN-F.
// It takes one CHI request at a time and looks it up across all ways of the set.
//   Hit            -> respond with the stored line.
//   Miss + SF hit  -> respond with a forward indication and do not allocate.
//   Miss + SF miss -> write back a dirty victim if needed, issue ReadNoSnp,
//                     install the fill as UC, then respond.
// Replacement uses the lowest invalid way, otherwise a per-set round-robin pointer.
// Ports:
//   clock, reset (async active-low)
//   req/req_v/req_ready                          : request in
//   sf_hit/sf_hit_state                          : snoop-filter result, valid in LOOKUP
//   read_no_snp/read_no_snp_v/read_no_snp_ready  : ReadNoSnp to the SN
//   wb_addr/wb_data/wb_v/wb_ready                : dirty victim writeback
//   fill_data/fill_txnid/fill_v/fill_ready       : fill return from the SN
//   rsp_v/rsp_ready/rsp_hit/rsp_fwd/rsp_state/rsp_data : response out

package slc_nway_pkg;
  localparam int unsigned CHI_NODEID_W    = 7;
  localparam int unsigned CHI_TXNID_W     = 12;
  localparam int unsigned CHI_ADDR_W      = 48;
  // The issued TxnID concatenates these low slices of TgtID and TxnID.
  // Their widths must sum to CHI_TXNID_W.
  localparam int unsigned CHI_MAX_SRCID_W = 4;
  localparam int unsigned CHI_MAX_TXNID_W = 8;

  typedef struct packed {
    logic [CHI_NODEID_W-1:0] TgtID;
    logic [CHI_NODEID_W-1:0] SrcID;
    logic [CHI_TXNID_W-1:0]  TxnID;
    logic [CHI_NODEID_W-1:0] ReturnNID;
    logic [CHI_TXNID_W-1:0]  ReturnTxnID;
    logic [5:0]              Opcode;
    logic [2:0]              Size;
    logic [CHI_ADDR_W-1:0]   Addr;
  } reqflit_t;
endpackage

module slc_nway
  import slc_nway_pkg::*;
#(
  parameter int unsigned ADDR_W   = 48,
  parameter int unsigned SET_W    = 7,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned WAYS     = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  reqflit_t                        req,
  input  logic                            req_v,
  output logic                            req_ready,
  input  logic                            sf_hit,
  input  logic [2:0]                      sf_hit_state,
  output reqflit_t                        read_no_snp,
  output logic                            read_no_snp_v,
  input  logic                            read_no_snp_ready,
  output logic [ADDR_W-1:0]               wb_addr,
  output logic [8*(2**OFFSET_W)-1:0]      wb_data,
  output logic                            wb_v,
  input  logic                            wb_ready,
  input  logic [8*(2**OFFSET_W)-1:0]      fill_data,
  input  logic [CHI_TXNID_W-1:0]          fill_txnid,
  input  logic                            fill_v,
  output logic                            fill_ready,
  output logic                            rsp_v,
  input  logic                            rsp_ready,
  output logic                            rsp_hit,
  output logic                            rsp_fwd,
  output logic [2:0]                      rsp_state,
  output logic [8*(2**OFFSET_W)-1:0]      rsp_data
);

  localparam int unsigned TAG_W   = ADDR_W - SET_W - OFFSET_W;
  localparam int unsigned LINE_W  = 8 * (2**OFFSET_W);
  localparam int unsigned SET_NUM = 2**SET_W;
  localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] LsUC = 3'b100;
  localparam logic [2:0] LsUD = 3'b110;
  localparam logic [2:0] LsSD = 3'b010;
  localparam logic [2:0] LsI  = 3'b001;
  localparam logic [5:0] OpReadNoSnp = 6'h04;

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StRns, StWait, StResp} state_e;

  state_e state_q, state_d;

  // Line storage: states are reset, tags/data are plain memory.
  logic [TAG_W-1:0]  tag_q  [SET_NUM][WAYS];
  logic [LINE_W-1:0] data_q [SET_NUM][WAYS];
  logic [2:0]        st_q   [SET_NUM][WAYS];
  logic [WAY_W-1:0]  ptr_q  [SET_NUM];

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WAY_W-1:0]       victim_q, victim_d;
  logic                   by_ptr_q, by_ptr_d;
  logic [CHI_TXNID_W-1:0] txnid_q, txnid_d;
  reqflit_t               rns_q, rns_d;
  logic [ADDR_W-1:0]      wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]      wb_data_q, wb_data_d;
  logic                   rsp_hit_q, rsp_hit_d, rsp_fwd_q, rsp_fwd_d;
  logic [2:0]             rsp_state_q, rsp_state_d;
  logic [LINE_W-1:0]      rsp_data_q, rsp_data_d;
  logic                   req_ready_q, fill_ready_q, rsp_v_q, wb_v_q, rns_v_q;

  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag_in;
  logic             hit, free;
  logic [WAY_W-1:0] hit_way, free_way, victim;
  logic [2:0]       victim_st;
  logic             st_we, line_we, ptr_we;
  logic [2:0]       st_wdata;

  // Request fields that this cache does not consume.
  logic unused_req;
  assign unused_req = ^{req.Opcode, req.ReturnNID, req.ReturnTxnID, sf_hit_state,
                        req.TgtID[CHI_NODEID_W-1:CHI_MAX_SRCID_W],
                        req.TxnID[CHI_TXNID_W-1:CHI_MAX_TXNID_W]};

  assign set_idx = addr_q[OFFSET_W +: SET_W];
  assign tag_in  = addr_q[ADDR_W-1 -: TAG_W];

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (st_q[set_idx][w] != LsI && tag_q[set_idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (st_q[set_idx][w] == LsI) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim    = free ? free_way : ptr_q[set_idx];
    victim_st = st_q[set_idx][victim];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    victim_d    = victim_q;
    by_ptr_d    = by_ptr_q;
    txnid_d     = txnid_q;
    rns_d       = rns_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_fwd_d   = rsp_fwd_q;
    rsp_state_d = rsp_state_q;
    rsp_data_d  = rsp_data_q;
    st_we       = 1'b0;
    st_wdata    = LsI;
    line_we     = 1'b0;
    ptr_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_v) begin
          addr_d            = req.Addr[ADDR_W-1:0];
          // ReadNoSnp payload depends only on the request, so build it now.
          rns_d             = '0;
          rns_d.Opcode      = OpReadNoSnp;
          rns_d.Addr        = req.Addr;
          rns_d.Size        = req.Size;
          rns_d.ReturnNID   = req.SrcID;
          rns_d.ReturnTxnID = req.TxnID;
          rns_d.SrcID       = req.TgtID;
          rns_d.TxnID       = {req.TgtID[CHI_MAX_SRCID_W-1:0], req.TxnID[CHI_MAX_TXNID_W-1:0]};
          state_d           = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          rsp_hit_d   = 1'b1;
          rsp_fwd_d   = 1'b0;
          rsp_state_d = st_q[set_idx][hit_way];
          rsp_data_d  = data_q[set_idx][hit_way];
          state_d     = StResp;
        end else if (sf_hit) begin
          rsp_hit_d   = 1'b0;
          rsp_fwd_d   = 1'b1;
          rsp_state_d = LsI;
          rsp_data_d  = '0;
          state_d     = StResp;
        end else begin
          victim_d = victim;
          by_ptr_d = !free;
          if (victim_st == LsUD || victim_st == LsSD) begin
            wb_addr_d = {tag_q[set_idx][victim], set_idx, {OFFSET_W{1'b0}}};
            wb_data_d = data_q[set_idx][victim];
            state_d   = StWb;
          end else begin
            state_d = StRns;
          end
        end
      end
      StWb: begin
        if (wb_ready) begin
          st_we   = 1'b1;
          state_d = StRns;
        end
      end
      StRns: begin
        if (read_no_snp_ready) begin
          txnid_d = rns_q.TxnID;
          state_d = StWait;
        end
      end
      StWait: begin
        // Fills with another TxnID are consumed and dropped.
        if (fill_v && fill_txnid == txnid_q) begin
          st_we       = 1'b1;
          st_wdata    = LsUC;
          line_we     = 1'b1;
          ptr_we      = by_ptr_q;
          rsp_hit_d   = 1'b0;
          rsp_fwd_d   = 1'b0;
          rsp_state_d = LsUC;
          rsp_data_d  = fill_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      victim_q     <= '0;
      by_ptr_q     <= 1'b0;
      txnid_q      <= '0;
      rns_q        <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_fwd_q    <= 1'b0;
      rsp_state_q  <= '0;
      rsp_data_q   <= '0;
      req_ready_q  <= 1'b1;
      fill_ready_q <= 1'b0;
      rsp_v_q      <= 1'b0;
      wb_v_q       <= 1'b0;
      rns_v_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      by_ptr_q     <= by_ptr_d;
      txnid_q      <= txnid_d;
      rns_q        <= rns_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_fwd_q    <= rsp_fwd_d;
      rsp_state_q  <= rsp_state_d;
      rsp_data_q   <= rsp_data_d;
      // Handshake outputs come straight from flops keyed on the next state.
      req_ready_q  <= (state_d == StIdle);
      fill_ready_q <= (state_d == StWait);
      rsp_v_q      <= (state_d == StResp);
      wb_v_q       <= (state_d == StWb);
      rns_v_q      <= (state_d == StRns);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(SET_NUM); s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) st_q[s][w] <= LsI;
      end
    end else begin
      if (st_we) st_q[set_idx][victim_q] <= st_wdata;
      if (ptr_we) begin
        ptr_q[set_idx] <= (ptr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                : ptr_q[set_idx] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (line_we) begin
      tag_q[set_idx][victim_q]  <= tag_in;
      data_q[set_idx][victim_q] <= fill_data;
    end
  end

  assign req_ready     = req_ready_q;
  assign fill_ready    = fill_ready_q;
  assign rsp_v         = rsp_v_q;
  assign wb_v          = wb_v_q;
  assign read_no_snp_v = rns_v_q;
  assign read_no_snp   = rns_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_fwd       = rsp_fwd_q;
  assign rsp_state     = rsp_state_q;
  assign rsp_data      = rsp_data_q;

endmodule
